// File: rtl/afifo_wr_burst_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port among NUM_REQ producers.
// A grant is held for a whole burst: until an accepted req_last or MAX_BURST accepted beats.
module afifo_wr_burst_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int MAX_BURST  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_wr_vld,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic [CNT_WIDTH-1:0]          beat_cnt
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t               state, state_next;
   logic [NUM_REQ-1:0]   grant_next;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic [IDX_W-1:0]     rr_ptr, rr_next;
   logic [IDX_W-1:0]     gidx;
   logic [IDX_W-1:0]     sel_idx;
   logic [IDX_W:0]       probe;
   logic                 sel_found;
   logic                 last_g;
   logic                 end_burst;

   // Rotating search: first requester at or above rr_ptr, wrapping past NUM_REQ-1.
   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      probe     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         probe = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (probe >= (IDX_W+1)'(NUM_REQ)) probe = probe - (IDX_W+1)'(NUM_REQ);
         if (!sel_found && req_valid[probe[IDX_W-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = probe[IDX_W-1:0];
         end
      end
   end

   // Datapath steered by the one-hot grant; all-zero grant yields all-zero outputs.
   always_comb begin
      gidx         = '0;
      fifo_wr_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            gidx         = IDX_W'(i);
            fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign req_ready  = grant & {NUM_REQ{fifo_wr_vld}};
   assign fifo_wr_en = (|(grant & req_valid)) & fifo_wr_vld;
   assign last_g     = |(grant & req_last);
   assign end_burst  = fifo_wr_en & (last_g | (beat_cnt == CNT_WIDTH'(MAX_BURST - 1)));
   assign busy       = (state == BURST);

   always_comb begin
      state_next = state;
      grant_next = grant;
      cnt_next   = beat_cnt;
      rr_next    = rr_ptr;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_next = BURST;
               grant_next = NUM_REQ'(1) << sel_idx;
               cnt_next   = '0;
            end
         end
         BURST: begin
            if (end_burst) begin
               state_next = IDLE;
               grant_next = '0;
               cnt_next   = '0;
               rr_next    = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
            end else if (fifo_wr_en) begin
               cnt_next   = beat_cnt + CNT_WIDTH'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         beat_cnt <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_next;
         grant    <= grant_next;
         beat_cnt <= cnt_next;
         rr_ptr   <= rr_next;
      end
   end

endmodule

// File: tb/tb_afifo_wr_burst_arbiter.sv
// Self-checking bench for afifo_wr_burst_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level arbiter model and a per-requester in-order scoreboard.
module tb_afifo_wr_burst_arbiter;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int MB = 16;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            fifo_wr_vld;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic [N-1:0]    grant;
   logic            busy;
   logic [CW-1:0]   beat_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 = nobody), beats accepted this grant, next priority index.
   int m_owner, m_beats, m_rr;
   logic [N-1:0]  e_grant, e_ready;
   logic          e_en, e_busy;
   logic [CW-1:0] e_cnt;
   logic [DW-1:0] e_data;

   afifo_wr_burst_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .fifo_wr_vld(fifo_wr_vld), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .grant(grant), .busy(busy), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mk(int r, int s);
      return {r[7:0], 24'hC0FFEE, s[31:0]};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_beats = 0;
      m_rr    = 0;
   endtask

   task automatic model_eval();
      e_grant = '0;
      e_ready = '0;
      e_en    = 1'b0;
      e_data  = '0;
      e_busy  = (m_owner >= 0);
      e_cnt   = CW'(m_beats);
      if (m_owner >= 0) begin
         e_grant[m_owner] = 1'b1;
         e_ready[m_owner] = fifo_wr_vld;
         e_en             = req_valid[m_owner] & fifo_wr_vld;
         e_data           = req_data[m_owner*DW +: DW];
      end
   endtask

   task automatic model_edge();
      bit found;
      found = 0;
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_rr + k) % N]) begin
               found   = 1;
               m_owner = (m_rr + k) % N;
               m_beats = 0;
            end
         end
      end else if (req_valid[m_owner] && fifo_wr_vld) begin
         m_beats++;
         if (req_last[m_owner] || m_beats == MB) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
            m_beats = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid   = '0;
      req_last    = '0;
      req_data    = '0;
      fifo_wr_vld = 1'b1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      req_valid   = '1;
      req_last    = '1;
      fifo_wr_vld = 1'b1;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = mk(i, 7);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (grant !== '0)        begin errors++; $display("FAIL reset_grant: got %h expected 0", grant); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (beat_cnt !== '0)     begin errors++; $display("FAIL reset_beat_cnt: got %0d expected 0", beat_cnt); end
      checks++; if (req_ready !== '0)    begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", fifo_wr_en); end
      checks++; if (fifo_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", fifo_wr_data); end
      @(negedge clk);
      idle_inputs();
      model_reset();
      rst = 1'b0;
   endtask

   task automatic test_single_burst();
      apply_reset();
      req_valid = 4'b0001;
      req_data[0 +: DW] = mk(0, 0);
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t1_grant_before: got %b expected 0000", grant); end
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t1_grant: got %b expected 0001", grant); end
      for (int b = 0; b < 3; b++) begin
         req_data[0 +: DW] = mk(0, b);
         req_last = (b == 2) ? 4'b0001 : 4'b0000;
         #1;
         checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL t1_wr_en beat %0d: got %b expected 1", b, fifo_wr_en); end
         checks++; if (fifo_wr_data !== mk(0, b)) begin errors++; $display("FAIL t1_wr_data beat %0d: got %h expected %h", b, fifo_wr_data, mk(0, b)); end
         tick();
      end
      req_valid = '0;
      req_last  = '0;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t1_grant_after: got %b expected 0000", grant); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL t1_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{1, 2, 4, 8, 1};
      logic [N-1:0] prev;
      int ng;
      apply_reset();
      prev = '0;
      ng   = 0;
      req_valid = '1;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = mk(i, 0);
      for (int cyc = 0; cyc < 15; cyc++) begin
         req_last = (m_beats == 1) ? '1 : '0;
         #1;
         model_eval();
         checks++; if (grant !== e_grant)   begin errors++; $display("FAIL t2_grant cyc %0d: got %b expected %b", cyc, grant, e_grant); end
         checks++; if (fifo_wr_en !== e_en) begin errors++; $display("FAIL t2_wr_en cyc %0d: got %b expected %b", cyc, fifo_wr_en, e_en); end
         if (grant != '0 && prev == '0) begin
            if (ng < 5) begin
               checks++;
               if (grant !== N'(exp_order[ng])) begin errors++; $display("FAIL t2_order %0d: got %b expected %b", ng, grant, N'(exp_order[ng])); end
            end
            ng++;
         end
         prev = grant;
         tick();
      end
      checks++; if (ng != 5) begin errors++; $display("FAIL t2_grant_count: got %0d expected 5", ng); end
   endtask

   task automatic test_max_burst();
      int exp_g[5] = '{4, 8, 1, 2, 4};
      int exp_l[5] = '{16, 1, 1, 1, 4};
      int q_grant[$];
      int q_len[$];
      bit served[N];
      logic [N-1:0] prev;
      int sent2;
      bit done;
      apply_reset();
      prev  = '0;
      sent2 = 0;
      done  = 0;
      for (int i = 0; i < N; i++) served[i] = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         req_valid = '0;
         req_last  = '0;
         if (sent2 < 20) begin
            req_valid[2] = 1'b1;
            req_last[2]  = (sent2 == 19);
            req_data[2*DW +: DW] = mk(2, sent2);
         end
         if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
               if (i != 2 && !served[i]) begin
                  req_valid[i] = 1'b1;
                  req_last[i]  = 1'b1;
                  req_data[i*DW +: DW] = mk(i, 0);
               end
            end
         end
         #1;
         model_eval();
         checks++; if (fifo_wr_en !== e_en)     begin errors++; $display("FAIL t3_wr_en cyc %0d: got %b expected %b", cyc, fifo_wr_en, e_en); end
         checks++; if (fifo_wr_data !== e_data) begin errors++; $display("FAIL t3_wr_data cyc %0d: got %h expected %h", cyc, fifo_wr_data, e_data); end
         if (grant != '0 && prev == '0) begin
            q_grant.push_back(int'(grant));
            q_len.push_back(0);
         end
         if (fifo_wr_en && q_len.size() > 0) q_len[q_len.size()-1]++;
         prev = grant;
         if (e_en) begin
            if (m_owner == 2) sent2++;
            else served[m_owner] = 1;
         end
         tick();
         done = (sent2 == 20) && served[0] && served[1] && served[3] && (m_owner < 0);
      end
      checks++; if (!done) begin errors++; $display("FAIL t3_timeout: sent2 %0d expected 20 within 200 cycles", sent2); end
      checks++; if (q_grant.size() != 5) begin errors++; $display("FAIL t3_grant_count: got %0d expected 5", q_grant.size()); end
      for (int k = 0; k < 5 && k < q_grant.size(); k++) begin
         checks++; if (q_grant[k] != exp_g[k]) begin errors++; $display("FAIL t3_grant %0d: got %0d expected %0d", k, q_grant[k], exp_g[k]); end
         checks++; if (q_len[k] != exp_l[k])   begin errors++; $display("FAIL t3_len %0d: got %0d expected %0d", k, q_len[k], exp_l[k]); end
      end
   endtask

   task automatic test_stall();
      int pat[4]  = '{1, 0, 0, 1};
      int ecnt[4] = '{0, 1, 1, 1};
      int acc;
      apply_reset();
      acc = 0;
      req_valid = 4'b0001;
      req_data[0 +: DW] = mk(0, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         fifo_wr_vld = (pat[k] != 0);
         req_data[0 +: DW] = mk(0, acc);
         #1;
         checks++; if (fifo_wr_en !== (pat[k] != 0))  begin errors++; $display("FAIL t4_wr_en %0d: got %b expected %0d", k, fifo_wr_en, pat[k]); end
         checks++; if (req_ready[0] !== (pat[k] != 0)) begin errors++; $display("FAIL t4_ready %0d: got %b expected %0d", k, req_ready[0], pat[k]); end
         checks++; if (beat_cnt !== CW'(ecnt[k]))      begin errors++; $display("FAIL t4_beat_cnt %0d: got %0d expected %0d", k, beat_cnt, ecnt[k]); end
         checks++; if (fifo_wr_data !== mk(0, acc))     begin errors++; $display("FAIL t4_wr_data %0d: got %h expected %h", k, fifo_wr_data, mk(0, acc)); end
         tick();
         if (pat[k] != 0) acc++;
      end
      #1;
      checks++; if (beat_cnt !== CW'(2)) begin errors++; $display("FAIL t4_beat_cnt_end: got %0d expected 2", beat_cnt); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      req_valid = 4'b0010;
      req_data[1*DW +: DW] = mk(1, 0);
      tick();
      for (int b = 0; b < 5; b++) begin
         req_data[1*DW +: DW] = mk(1, b);
         tick();
      end
      req_valid = '1;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = mk(i, 5);
      #1;
      checks++; if (beat_cnt !== CW'(5)) begin errors++; $display("FAIL t5_beat_cnt: got %0d expected 5", beat_cnt); end
      checks++; if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL t5_wr_en_pre: got %b expected 1", fifo_wr_en); end
      #1;
      rst = 1'b1;
      model_reset();
      #1;
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL t5_wr_en_rst: got %b expected 0", fifo_wr_en); end
      checks++; if (grant !== '0)        begin errors++; $display("FAIL t5_grant_rst: got %b expected 0000", grant); end
      checks++; if (req_ready !== '0)    begin errors++; $display("FAIL t5_ready_rst: got %b expected 0000", req_ready); end
      checks++; if (beat_cnt !== '0)     begin errors++; $display("FAIL t5_cnt_rst: got %0d expected 0", beat_cnt); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL t5_wr_en_held: got %b expected 0", fifo_wr_en); end
      rst = 1'b0;
      tick();
      #1;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t5_grant_after: got %b expected 0001", grant); end
   endtask

   task automatic test_random();
      int seq[N];
      int sb[N];
      int err0;
      int r;
      apply_reset();
      err0 = errors;
      for (int i = 0; i < N; i++) begin seq[i] = 0; sb[i] = 0; end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom_range(0, 9) < 7);
            req_last[i]  = ($urandom_range(0, 4) == 0);
            req_data[i*DW +: DW] = mk(i, seq[i]);
         end
         fifo_wr_vld = ($urandom_range(0, 3) != 0);
         #1;
         model_eval();
         checks++;
         if ({grant, busy, beat_cnt, req_ready, fifo_wr_en, fifo_wr_data} !==
             {e_grant, e_busy, e_cnt, e_ready, e_en, e_data}) begin
            errors++;
            $display("FAIL t6_outputs cyc %0d: got g=%b b=%b c=%0d r=%b en=%b d=%h expected g=%b b=%b c=%0d r=%b en=%b d=%h",
                     cyc, grant, busy, beat_cnt, req_ready, fifo_wr_en, fifo_wr_data,
                     e_grant, e_busy, e_cnt, e_ready, e_en, e_data);
         end
         checks++; if (fifo_wr_en && !fifo_wr_vld) begin errors++; $display("FAIL t6_en_without_vld cyc %0d: got en=1 vld=0 expected en=0", cyc); end
         checks++; if (!$onehot0(req_ready))       begin errors++; $display("FAIL t6_ready_onehot cyc %0d: got %b expected at most one bit", cyc, req_ready); end
         checks++; if (!$onehot0(grant))           begin errors++; $display("FAIL t6_grant_onehot cyc %0d: got %b expected at most one bit", cyc, grant); end
         if (fifo_wr_en) begin
            r = int'(fifo_wr_data[63:56]);
            checks++;
            if (r >= N) begin
               errors++; $display("FAIL t6_sb_id cyc %0d: got id %0d expected below %0d", cyc, r, N);
            end else begin
               if (fifo_wr_data !== mk(r, sb[r])) begin
                  errors++; $display("FAIL t6_sb_order cyc %0d: got %h expected %h", cyc, fifo_wr_data, mk(r, sb[r]));
               end
               sb[r]++;
            end
         end
         for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
         tick();
         if (errors > err0 + 10) break;
      end
      for (int i = 0; i < N; i++) begin
         checks++; if (sb[i] != seq[i]) begin errors++; $display("FAIL t6_sb_count req %0d: got %0d writes expected %0d", i, sb[i], seq[i]); end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      test_reset();
      test_single_burst();
      test_round_robin();
      test_max_burst();
      test_stall();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
